light_actuated_seq: RTL and testbench

Parametrised, sensor-actuated four-way stop-light controller; the next generation of the fixed-rotation intersection sequencer. It drives one intersection's four approach lights. It rotates N→E→S→W, supports minimum/maximum green, gap-out on lost demand, skipping of empty approaches and an all-Stop clearance interval. A MODE parameter selects fixed-time rotation (legacy behaviour) or actuated operation, and user-placed general sensors can be OR-ed into any approach's demand.

---
 rtl/light_actuated_seq.sv | 149 ++++++++++++++
 tb/tb_light_actuated_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/light_actuated_seq.sv
// Sensor-actuated four-way stop-light controller.
// Rotates N->E->S->W with min/max green, gap-out, skip and all-Stop clearance.
module light_actuated_seq #(
  parameter int          MODE      = 1,
  parameter int          CNT_W     = 8,
  parameter int          MIN_GREEN = 16,
  parameter int          MAX_GREEN = 64,
  parameter int          CLEAR     = 4,
  parameter int          SENS_N    = 6,
  parameter int          SENS_S    = 4,
  parameter int          SENS_E    = 5,
  parameter int          SENS_W    = 7,
  parameter logic [31:0] GMASK_N   = 32'h0,
  parameter logic [31:0] GMASK_S   = 32'h0,
  parameter logic [31:0] GMASK_E   = 32'h0,
  parameter logic [31:0] GMASK_W   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sensor_light,
  input  logic [31:0] general_sensors,
  output logic [2:0]  outN,
  output logic [2:0]  outS,
  output logic [2:0]  outE,
  output logic [2:0]  outW,
  output logic [1:0]  phase_dir,
  output logic        in_clear
);

  localparam logic [2:0] LIGHT_GO   = 3'b100;
  localparam logic [2:0] LIGHT_STOP = 3'b000;

  localparam logic [CNT_W-1:0] MAX_T = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] MIN_T = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] CLR_T = CNT_W'(CLEAR - 1);

  typedef enum logic {
    S_GREEN = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e           st_q, st_d;
  logic [1:0]       dir_q, dir_d;
  logic [CNT_W-1:0] timer_q, timer_d;

  // Demand vector indexed by direction code: 0=N, 1=E, 2=S, 3=W.
  logic [3:0] dem;
  logic       dem_dir;
  logic       other_dem;

  assign dem[0] = sensor_light[SENS_N] | (|(general_sensors & GMASK_N));
  assign dem[1] = sensor_light[SENS_E] | (|(general_sensors & GMASK_E));
  assign dem[2] = sensor_light[SENS_S] | (|(general_sensors & GMASK_S));
  assign dem[3] = sensor_light[SENS_W] | (|(general_sensors & GMASK_W));

  assign dem_dir   = dem[dir_q];
  assign other_dem = |(dem & ~(4'b0001 << dir_q));

  // Actuated next approach: first demanding one after dir_q, else stay.
  logic [1:0] act_dir;
  logic [1:0] cand;
  logic       found;

  always_comb begin
    act_dir = dir_q;
    cand    = dir_q;
    found   = 1'b0;
    for (int k = 1; k < 4; k++) begin
      cand = dir_q + 2'(k);
      if (!found && dem[cand]) begin
        act_dir = cand;
        found   = 1'b1;
      end
    end
  end

  logic at_max;
  logic past_min;
  logic green_exit;

  assign at_max   = (timer_q == MAX_T);
  assign past_min = (timer_q >= MIN_T);

  always_comb begin
    green_exit = 1'b0;
    if (MODE == 0) begin
      green_exit = at_max;
    end else begin
      green_exit = (past_min & ~dem_dir & other_dem)
                 | (at_max & other_dem);
    end
  end

  always_comb begin
    st_d    = st_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    unique case (st_q)
      S_GREEN: begin
        if (green_exit) begin
          st_d    = S_CLEAR;
          timer_d = '0;
        end else if (!at_max) begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_CLEAR: begin
        if (timer_q == CLR_T) begin
          st_d    = S_GREEN;
          timer_d = '0;
          if (MODE == 0) begin
            dir_d = dir_q + 2'd1;
          end else begin
            dir_d = act_dir;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        st_d    = S_GREEN;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= S_GREEN;
      dir_q   <= 2'd0;
      timer_q <= '0;
    end else begin
      st_q    <= st_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
    end
  end

  logic green;
  assign green = (st_q == S_GREEN);

  assign outN      = (green && dir_q == 2'd0) ? LIGHT_GO : LIGHT_STOP;
  assign outE      = (green && dir_q == 2'd1) ? LIGHT_GO : LIGHT_STOP;
  assign outS      = (green && dir_q == 2'd2) ? LIGHT_GO : LIGHT_STOP;
  assign outW      = (green && dir_q == 2'd3) ? LIGHT_GO : LIGHT_STOP;
  assign phase_dir = dir_q;
  assign in_clear  = (st_q == S_CLEAR);

endmodule

// File: tb/tb_light_actuated_seq.sv
// Bench for light_actuated_seq: actuated and fixed-time instances,
// per-cycle expected vectors queued by stimulus and checked by a monitor.
module tb_light_actuated_seq;

  logic        clk;
  logic        rst1, rst0;
  logic [7:0]  sensor_light;
  logic [31:0] general_sensors;

  logic [2:0] n1, s1, e1, w1, n0, s0, e0, w0;
  logic [1:0] pd1, pd0;
  logic       ic1, ic0;

  light_actuated_seq #(
    .MODE(1), .CNT_W(8), .MIN_GREEN(4), .MAX_GREEN(8), .CLEAR(2),
    .GMASK_S(32'h8)
  ) u_act (
    .clk(clk), .rst(rst1),
    .sensor_light(sensor_light), .general_sensors(general_sensors),
    .outN(n1), .outS(s1), .outE(e1), .outW(w1),
    .phase_dir(pd1), .in_clear(ic1)
  );

  light_actuated_seq #(
    .MODE(0), .CNT_W(8), .MIN_GREEN(4), .MAX_GREEN(8), .CLEAR(2)
  ) u_fix (
    .clk(clk), .rst(rst0),
    .sensor_light(sensor_light), .general_sensors(general_sensors),
    .outN(n0), .outS(s0), .outE(e0), .outW(w0),
    .phase_dir(pd0), .in_clear(ic0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          dut;
    logic [14:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [14:0] vec_of(input bit dut);
    if (dut) return {n1, s1, e1, w1, pd1, ic1};
    return {n0, s0, e0, w0, pd0, ic0};
  endfunction

  // Expected green on approach d: {N,S,E,W,phase_dir,in_clear}
  function automatic logic [14:0] G(input logic [1:0] d);
    logic [2:0] n, s, e, w;
    n = (d == 2'd0) ? 3'b100 : 3'b000;
    e = (d == 2'd1) ? 3'b100 : 3'b000;
    s = (d == 2'd2) ? 3'b100 : 3'b000;
    w = (d == 2'd3) ? 3'b100 : 3'b000;
    return {n, s, e, w, d, 1'b0};
  endfunction

  function automatic logic [14:0] C(input logic [1:0] d);
    return {12'h000, d, 1'b1};
  endfunction

  task automatic cmp(input string nm, input logic [14:0] act,
                     input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got N%b S%b E%b W%b pd%0d clr%b, want N%b S%b E%b W%b pd%0d clr%b",
               nm, act[14:12], act[11:9], act[8:6], act[5:3], act[2:1], act[0],
               exp[14:12], exp[11:9], exp[8:6], exp[5:3], exp[2:1], exp[0]);
    end
  endtask

  // Monitor: one expected vector per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp(e.name, vec_of(e.dut), e.exp);
    end
  end

  task automatic expect_n(input bit dut, input logic [14:0] v,
                          input int n, input string nm);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.dut  = dut;
      e.exp  = v;
      e.name = nm;
      q.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  // Asynchronous reset: outputs must settle before any clock edge.
  task automatic pulse_rst(input bit dut, input string nm);
    if (dut) rst1 = 1'b1;
    else     rst0 = 1'b1;
    #1;
    cmp(nm, vec_of(dut), G(2'd0));
    @(posedge clk);
    #1;
    if (dut) rst1 = 1'b0;
    else     rst0 = 1'b0;
  endtask

  initial begin
    rst1            = 1'b1;
    rst0            = 1'b1;
    sensor_light    = 8'h00;
    general_sensors = 32'h0;
    #1;
    cmp("reset_act", vec_of(1'b1), G(2'd0));
    cmp("reset_fix", vec_of(1'b0), G(2'd0));
    @(posedge clk);
    #1;
    rst1 = 1'b0;

    expect_n(1'b1, G(2'd0), 100, "idle_N");

    sensor_light = 8'h20;
    pulse_rst(1'b1, "rst_gap");
    expect_n(1'b1, G(2'd0), 4, "gap_N");
    expect_n(1'b1, C(2'd0), 2, "gap_clr");
    expect_n(1'b1, G(2'd1), 6, "gap_E_hold");

    sensor_light = 8'hC0;
    pulse_rst(1'b1, "rst_max");
    expect_n(1'b1, G(2'd0), 8, "max_N");
    expect_n(1'b1, C(2'd0), 2, "max_clr1");
    expect_n(1'b1, G(2'd3), 8, "skip_W");
    expect_n(1'b1, C(2'd3), 2, "max_clr2");
    expect_n(1'b1, G(2'd0), 2, "wrap_N");

    sensor_light    = 8'h00;
    general_sensors = 32'h8;
    pulse_rst(1'b1, "rst_gen");
    expect_n(1'b1, G(2'd0), 4, "gen_N");
    expect_n(1'b1, C(2'd0), 2, "gen_clr");
    expect_n(1'b1, G(2'd2), 4, "gen_S");

    general_sensors = 32'h0;
    sensor_light    = 8'h20;
    pulse_rst(1'b1, "rst_regreen");
    expect_n(1'b1, G(2'd0), 4, "rg_N");
    sensor_light = 8'h00;
    expect_n(1'b1, C(2'd0), 2, "rg_clr");
    expect_n(1'b1, G(2'd0), 3, "rg_N_again");

    rst1            = 1'b1;
    sensor_light    = 8'hFF;
    general_sensors = 32'hFFFF_FFFF;
    rst0            = 1'b0;
    for (int d = 0; d < 4; d++) begin
      expect_n(1'b0, G(2'(d)), 8, "fix_green");
      expect_n(1'b0, C(2'(d)), 2, "fix_clr");
    end
    expect_n(1'b0, G(2'd0), 8, "fix_N2");
    expect_n(1'b0, C(2'd0), 2, "fix_clr2");
    expect_n(1'b0, G(2'd1), 8, "fix_E2");
    expect_n(1'b0, C(2'd1), 2, "fix_clr3");
    expect_n(1'b0, G(2'd2), 3, "fix_S_mid");
    pulse_rst(1'b0, "fix_async_rst");
    expect_n(1'b0, G(2'd0), 2, "fix_after_rst");

    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL queue_drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
